// File: rtl/alu_rx_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_rx_sequencer_if
// Bundles every non-clock/reset signal of alu_rx_sequencer.
//   i_rx_data/i_rx_valid  : byte stream from the UART receiver (no backpressure)
//   o_alu_a/o_alu_b/o_alu_op : registered operands and opcode toward the ALU
//   i_alu_result          : combinational ALU result
//   o_res_data/o_res_valid/i_res_ready : result handshake toward the transmitter
//   o_err/o_overrun/o_busy: status (error pulse, dropped-byte pulse, busy level)
// Modport slave is the sequencer's view; master is the surrounding system's.
// ---------------------------------------------------------------------------
interface alu_rx_sequencer_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
);
  logic [NB_DATA-1:0] i_rx_data;
  logic               i_rx_valid;
  logic [NB_DATA-1:0] o_alu_a;
  logic [NB_DATA-1:0] o_alu_b;
  logic [NB_OP-1:0]   o_alu_op;
  logic [NB_DATA-1:0] i_alu_result;
  logic [NB_DATA-1:0] o_res_data;
  logic               o_res_valid;
  logic               i_res_ready;
  logic               o_err;
  logic               o_overrun;
  logic               o_busy;

  modport slave (
    input  i_rx_data, i_rx_valid, i_alu_result, i_res_ready,
    output o_alu_a, o_alu_b, o_alu_op, o_res_data, o_res_valid,
           o_err, o_overrun, o_busy
  );

  modport master (
    output i_rx_data, i_rx_valid, i_alu_result, i_res_ready,
    input  o_alu_a, o_alu_b, o_alu_op, o_res_data, o_res_valid,
           o_err, o_overrun, o_busy
  );
endinterface

// File: rtl/alu_rx_sequencer.sv
// ---------------------------------------------------------------------------
// alu_rx_sequencer
// Collects three bytes (operand A, operand B, opcode) from the receive
// stream, presents them to the combinational ALU from registers, captures
// the result one cycle later and offers it on a valid/ready handshake.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : synchronous reset, active low
//   bus    : alu_rx_sequencer_if.slave (rx stream, ALU lanes, result
//            handshake, o_err / o_overrun pulses, o_busy level)
// Parameters: NB_DATA operand width, NB_OP opcode width, TIMEOUT idle
// cycles tolerated between bytes of one frame (>= 2).
// ---------------------------------------------------------------------------
module alu_rx_sequencer #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6,
  parameter int TIMEOUT = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_rx_sequencer_if.slave   bus
);

  localparam int CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int N_LEGAL = 8;
  // ADD, SUB, SRL, SRA, AND, OR, XOR, NOR; only the low NB_OP bits matter.
  localparam logic [N_LEGAL*8-1:0] LEGAL_OPS =
    {8'h20, 8'h22, 8'h02, 8'h03, 8'h24, 8'h25, 8'h26, 8'h27};

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    EXEC,
    SEND
  } state_t;

  state_t             state_q, state_d;
  logic [NB_DATA-1:0] alu_a_q, alu_a_d;
  logic [NB_DATA-1:0] alu_b_q, alu_b_d;
  logic [NB_OP-1:0]   alu_op_q, alu_op_d;
  logic [NB_DATA-1:0] res_data_q, res_data_d;
  logic               res_valid_q, res_valid_d;
  logic               err_q, err_d;
  logic               overrun_q, overrun_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NB_OP-1:0]   rx_op;
  logic [N_LEGAL-1:0] op_hit;
  logic               op_legal;
  logic               timeout_hit;

  assign rx_op = bus.i_rx_data[NB_OP-1:0];

  // One comparator per legal opcode; any hit makes the opcode byte legal.
  generate
    for (genvar gi = 0; gi < N_LEGAL; gi++) begin : g_op_match
      assign op_hit[gi] = (rx_op == LEGAL_OPS[gi*8 +: NB_OP]);
    end
  endgenerate

  assign op_legal    = |op_hit;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    err_d       = 1'b0;
    overrun_d   = 1'b0;
    cnt_d       = '0;

    case (state_q)
      WAIT_A: begin
        if (bus.i_rx_valid) begin
          alu_a_d = bus.i_rx_data;
          state_d = WAIT_B;
        end
      end

      WAIT_B: begin
        // A byte on the timeout cycle still wins over the timeout.
        if (bus.i_rx_valid) begin
          alu_b_d = bus.i_rx_data;
          state_d = WAIT_OP;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = WAIT_A;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WAIT_OP: begin
        if (bus.i_rx_valid) begin
          if (op_legal) begin
            alu_op_d = rx_op;
            state_d  = EXEC;
          end else begin
            err_d   = 1'b1;
            state_d = WAIT_A;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = WAIT_A;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      EXEC: begin
        // ALU inputs have been stable from registers for this whole cycle.
        res_data_d  = bus.i_alu_result;
        res_valid_d = 1'b1;
        overrun_d   = bus.i_rx_valid;
        state_d     = SEND;
      end

      SEND: begin
        // Bytes are dropped here, including on the handshake cycle itself.
        overrun_d = bus.i_rx_valid;
        if (bus.i_res_ready) begin
          res_valid_d = 1'b0;
          state_d     = WAIT_A;
        end
      end

      default: begin
        state_d = WAIT_A;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= WAIT_A;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
      overrun_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
      overrun_q   <= overrun_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.o_alu_a     = alu_a_q;
  assign bus.o_alu_b     = alu_b_q;
  assign bus.o_alu_op    = alu_op_q;
  assign bus.o_res_data  = res_data_q;
  assign bus.o_res_valid = res_valid_q;
  assign bus.o_err       = err_q;
  assign bus.o_overrun   = overrun_q;
  assign bus.o_busy      = (state_q == EXEC) || (state_q == SEND);

endmodule
